dm_lsu_ram: RTL

Parametrised RISC-V data memory for the MEM stage: accepts load/store requests over a valid/ready handshake, applies funct3-based byte/half/word access with byte-lane write enables, and returns sign- or zero-extended load data from a one-deep registered response. A second, independent synchronous read port serves top-level inspection. The block detects misaligned, out-of-range and illegal-size accesses and flags them as errors; it does not raise traps itself.

---
 rtl/dm_pkg.sv | 36 +++
 rtl/dm_lsu_ram_if.sv | 31 +++
 rtl/byte_lane_ram.sv | 37 +++
 rtl/dm_lsu_ram.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 codes and the
// byte-lane enable / load-extension helpers used by the top.
package dm_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_SB:   return 4'b0001 << offset;
            F3_SH:   return 4'b0011 << offset;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Lane selection by offset, then sign or zero extension to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                                input logic [1:0] offset);
        case (funct3)
            F3_LB:   return {{24{word[{offset, 3'b000} + 7]}}, word[{offset, 3'b000} +: 8]};
            F3_LH:   return {{16{word[{offset[1], 4'b0000} + 15]}}, word[{offset[1], 4'b0000} +: 16]};
            F3_LW:   return word;
            F3_LBU:  return {24'h000000, word[{offset, 3'b000} +: 8]};
            F3_LHU:  return {16'h0000, word[{offset[1], 4'b0000} +: 16]};
            default: return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_ram_if.sv
// MEM-stage request/response bus plus the debug read port of dm_lsu_ram.
interface dm_lsu_ram_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]           req_wdata_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [31:0]           resp_rdata_o;
    logic                  resp_err_o;
    logic                  dbg_rd_en_i;
    logic [ADDR_WIDTH-1:0] dbg_addr_i;
    logic [31:0]           dbg_rdata_o;
    logic                  dbg_valid_o;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output resp_ready_i, dbg_rd_en_i, dbg_addr_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, dbg_rdata_o, dbg_valid_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  resp_ready_i, dbg_rd_en_i, dbg_addr_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, dbg_rdata_o, dbg_valid_o
    );
endinterface

// File: rtl/byte_lane_ram.sv
// One byte lane of the data memory: single write port, two registered read
// ports. Reads return the pre-write contents when addresses collide.
module byte_lane_ram #(
    parameter int  DEPTH_WORDS = 16384,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic             a_en,
    input  logic [IDX_W-1:0] a_addr,
    output logic [7:0]       a_rdata,
    input  logic             b_en,
    input  logic [IDX_W-1:0] b_addr,
    output logic [7:0]       b_rdata
);
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end
endmodule

// File: rtl/dm_lsu_ram.sv
// RISC-V MEM-stage data memory: byte/half/word load-store with error flagging,
// a one-deep response register and an independent debug read port.
module dm_lsu_ram
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 16384
) (
    input logic         sys_clk_i,
    input logic         rst_i,
    dm_lsu_ram_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [ADDR_WIDTH-1:0] req_word;
    logic [ADDR_WIDTH-1:0] dbg_word;
    logic [1:0]            req_off;
    logic                  req_oob;
    logic                  dbg_oob;
    logic                  req_legal;
    logic                  req_misaligned;
    logic                  req_err;
    logic                  accept;
    logic                  wr_en;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           load_word;
    logic [31:0]           dbg_word_rd;

    logic                  resp_valid_reg;
    logic                  resp_we_reg;
    logic                  resp_err_reg;
    logic [2:0]            resp_funct3_reg;
    logic [1:0]            resp_off_reg;
    logic                  dbg_valid_reg;
    logic                  dbg_zero_reg;

    assign req_word = bus.req_addr_i >> 2;
    assign dbg_word = bus.dbg_addr_i >> 2;
    assign req_off  = bus.req_addr_i[1:0];
    assign req_oob  = req_word >= ADDR_WIDTH'(DEPTH_WORDS);
    assign dbg_oob  = dbg_word >= ADDR_WIDTH'(DEPTH_WORDS);

    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (bus.req_we_i) begin
            req_legal = bus.req_funct3_i inside {F3_SB, F3_SH, F3_SW};
        end else begin
            req_legal = bus.req_funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end
        case (bus.req_funct3_i[1:0])
            2'd1:    req_misaligned = req_off[0];
            2'd2:    req_misaligned = (req_off != 2'd0);
            default: req_misaligned = 1'b0;
        endcase
        req_err = !req_legal || req_misaligned || req_oob;
    end

    assign bus.req_ready_o = !rst_i && (!resp_valid_reg || bus.resp_ready_i);
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign wr_en           = accept && bus.req_we_i && !req_err;
    assign be              = byte_enable(bus.req_funct3_i, req_off);

    // Replicate narrow store data so every enabled lane already sees its byte.
    always_comb begin
        wdata_rep = bus.req_wdata_i;
        case (bus.req_funct3_i)
            F3_SB:   wdata_rep = {4{bus.req_wdata_i[7:0]}};
            F3_SH:   wdata_rep = {2{bus.req_wdata_i[15:0]}};
            default: wdata_rep = bus.req_wdata_i;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            byte_lane_ram #(
                .DEPTH_WORDS(DEPTH_WORDS)
            ) u_lane (
                .clk    (sys_clk_i),
                .we     (wr_en && be[gi]),
                .waddr  (req_word[IDX_W-1:0]),
                .wdata  (wdata_rep[8*gi +: 8]),
                .a_en   (accept && !bus.req_we_i),
                .a_addr (req_word[IDX_W-1:0]),
                .a_rdata(load_word[8*gi +: 8]),
                .b_en   (bus.dbg_rd_en_i && !rst_i),
                .b_addr (dbg_word[IDX_W-1:0]),
                .b_rdata(dbg_word_rd[8*gi +: 8])
            );
        end
    endgenerate

    // RAM read registers only advance on accept / debug enable, so the
    // outputs below stay stable during a stall without extra data registers.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            resp_valid_reg  <= 1'b0;
            resp_we_reg     <= 1'b0;
            resp_err_reg    <= 1'b0;
            resp_funct3_reg <= 3'd0;
            resp_off_reg    <= 2'd0;
            dbg_valid_reg   <= 1'b0;
            dbg_zero_reg    <= 1'b1;
        end else begin
            if (accept) begin
                resp_valid_reg  <= 1'b1;
                resp_we_reg     <= bus.req_we_i;
                resp_err_reg    <= req_err;
                resp_funct3_reg <= bus.req_funct3_i;
                resp_off_reg    <= req_off;
            end else if (bus.resp_ready_i) begin
                resp_valid_reg <= 1'b0;
            end
            dbg_valid_reg <= bus.dbg_rd_en_i;
            if (bus.dbg_rd_en_i) begin
                dbg_zero_reg <= dbg_oob;
            end
        end
    end

    assign bus.resp_valid_o = resp_valid_reg;
    assign bus.resp_err_o   = resp_valid_reg && resp_err_reg;
    assign bus.resp_rdata_o = (resp_valid_reg && !resp_we_reg && !resp_err_reg)
                            ? load_extend(load_word, resp_funct3_reg, resp_off_reg) : 32'h0;
    assign bus.dbg_valid_o  = dbg_valid_reg;
    assign bus.dbg_rdata_o  = dbg_zero_reg ? 32'h0 : dbg_word_rd;
endmodule
